// File: rtl/dm_pkg.sv
// Shared constants for the data-memory responder.
// State encoding, bus widths and the fault flag value.
package dm_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    localparam logic ERR_FAULT = 1'b1;

endpackage

// File: rtl/dm_ram.sv
// Word array behind the responder.
// Byte-enabled synchronous write, combinational read.
module dm_ram
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [BE_W-1:0]       be,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Write only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for the CPU data port.
// Serves load/store requests after WAIT_CYCLES wait states.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] LAST_CNT  =
        ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic [31:0]       off;
    logic [31:0]       word;
    logic [31:0]       word_hi;
    logic              fault;
    logic              enter_resp;
    logic              ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DATA_W-1:0] ram_rdata;

    // With zero wait states the access completes on the accept edge,
    // so the live inputs are used in IDLE and the latched copy otherwise
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_be    = be;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
        off     = cur_addr - BASE_ADDR;
        word    = off >> 2;
        word_hi = word >> DEPTH_LOG2;
        fault   = (cur_addr[1:0] != 2'b00) || (word_hi != 32'd0);
        ram_idx = word[DEPTH_LOG2-1:0];
    end

    // FSM, wait counter and request latches
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = 4'd0;
                    if (ZERO_WAIT) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d    = ST_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Commit and response data are produced on the edge entering RESP
    always_comb begin
        ram_we  = enter_resp && cur_we && !fault;
        ack_d   = enter_resp;
        rdata_d = '0;
        err_d   = 1'b0;
        if (enter_resp) begin
            if (fault) begin
                err_d = ERR_FAULT;
            end else if (!cur_we) begin
                rdata_d = ram_rdata;
            end
        end
    end

    // State and output registers, aborted by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    dm_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .idx  (ram_idx),
        .wdata(cur_wdata),
        .be   (cur_be),
        .rdata(ram_rdata)
    );

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder.
// Instance 0 runs with 2 wait states, instance 1 with none.
module tb_dm_responder;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  be_s    [2];
    logic        ack_s   [2];
    logic [31:0] rdata_s [2];
    logic        err_s   [2];
    logic        busy_s  [2];

    exp_t sb [2][$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_responder #(
            .DEPTH_LOG2 (10),
            .WAIT_CYCLES(g == 0 ? 2 : 0),
            .BASE_ADDR  (32'h0000_0000)
        ) u_dut (
            .clk  (clk),
            .reset(rst_n),
            .req  (req_s[g]),
            .we   (we_s[g]),
            .addr (addr_s[g]),
            .wdata(wdata_s[g]),
            .be   (be_s[g]),
            .ack  (ack_s[g]),
            .rdata(rdata_s[g]),
            .err  (err_s[g]),
            .busy (busy_s[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pop the expected response whenever a DUT acks
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (ack_s[s] === 1'b1) begin
                if (sb[s].size() == 0) begin
                    chk($sformatf("spurious_ack%0d", s), 1, 0);
                end else begin
                    exp_t e;
                    e = sb[s].pop_front();
                    chk($sformatf("rdata%0d", s), rdata_s[s], e.rd);
                    chk($sformatf("err%0d", s), 32'(err_s[s]), 32'(e.err));
                    chk($sformatf("lat%0d", s), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic wait_ack(input int s);
        int n;
        n = 0;
        while (ack_s[s] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ack_seen%0d", s), 32'(ack_s[s]), 1);
    endtask

    task automatic acc(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] erd, input logic eerr);
        exp_t e;
        @(negedge clk);
        req_s[s]   = 1'b1;
        we_s[s]    = w;
        addr_s[s]  = a;
        wdata_s[s] = d;
        be_s[s]    = b;
        e.rd  = erd;
        e.err = eerr;
        e.cyc = cyc + 1 + (s == 0 ? 2 : 0);
        sb[s].push_back(e);
        @(negedge clk);
        wait_ack(s);
        req_s[s] = 1'b0;
        @(negedge clk);
        chk($sformatf("ack_pulse%0d", s), 32'(ack_s[s]), 0);
        chk($sformatf("idle%0d", s), 32'(busy_s[s]), 0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_s[s]   = 1'b0;
            we_s[s]    = 1'b0;
            addr_s[s]  = '0;
            wdata_s[s] = '0;
            be_s[s]    = '0;
        end
        rst_n    = 1'b0;
        req_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ack", 32'(ack_s[0]), 0);
            chk("rst_rdata", rdata_s[0], 0);
            chk("rst_err", 32'(err_s[0]), 0);
            chk("rst_busy", 32'(busy_s[0]), 0);
        end
        req_s[0] = 1'b0;
        rst_n    = 1'b1;

        acc(0, 1, 32'h0, 32'hCAFE_0000, 4'hF, 32'h0, 0);
        acc(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
        acc(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);

        acc(0, 1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 0);
        acc(0, 1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 0);
        acc(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 0);
        acc(0, 1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'h0, 0);
        acc(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 0);

        acc(0, 0, 32'h13, 32'h0, 4'h0, 32'h0, 1);
        acc(0, 1, 32'h1000, 32'h1234_5678, 4'hF, 32'h0, 1);
        acc(0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFE_0000, 0);
        acc(0, 1, 32'h12, 32'h1234_5678, 4'hF, 32'h0, 1);
        acc(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);

        acc(0, 1, 32'h40, 32'h0BAD_F00D, 4'hF, 32'h0, 0);
        @(negedge clk);
        req_s[0]   = 1'b1;
        we_s[0]    = 1'b1;
        addr_s[0]  = 32'h40;
        wdata_s[0] = 32'h55AA_55AA;
        be_s[0]    = 4'hF;
        @(negedge clk);
        chk("abort_busy", 32'(busy_s[0]), 1);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_ack", 32'(ack_s[0]), 0);
            chk("abort_busy_rst", 32'(busy_s[0]), 0);
        end
        req_s[0] = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_noack", 32'(ack_s[0]), 0);
        end
        acc(0, 0, 32'h40, 32'h0, 4'h0, 32'h0BAD_F00D, 0);

        for (int k = 0; k < 4; k++) begin
            acc(1, 1, 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF, 32'h0, 0);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.rd  = 32'hA000_0000 + 32'(k);
            e.err = 1'b0;
            e.cyc = cyc + 1 + 2 * k;
            sb[1].push_back(e);
        end
        req_s[1]  = 1'b1;
        we_s[1]   = 1'b0;
        addr_s[1] = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            wait_ack(1);
            if (k < 4) addr_s[1] = 32'(4 * k);
        end
        req_s[1] = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(sb[0].size() + sb[1].size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
